// File: rtl/uart_pix_assembler_pkg.sv
// Shared constants and types for the UART pixel assembler.
// pix_entry_t is sized for the default 3-byte pixel; the top builds its own entry type from its parameters.
package uart_pix_assembler_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int unsigned PIX_W_DFLT = 24;

  typedef enum logic [1:0] {IDLE, RECV, DONE} asm_state_e;

  typedef struct packed {
    logic                  sof;
    logic                  eol;
    logic [PIX_W_DFLT-1:0] pix;
  } pix_entry_t;
endpackage

// File: rtl/uart_pix_assembler_sync_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_pix_assembler_sync_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  // Head reads as zero while empty so the stream outputs are clean after reset.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/uart_pix_assembler.sv
// Parses SYNC-headed frames from the UART byte stream, packs little-endian pixels and
// streams them out through a FIFO with start-of-frame / end-of-line sideband.
module uart_pix_assembler
  import uart_pix_assembler_pkg::*;
#(
  parameter int unsigned BYTES_PER_PIX = 3,
  parameter int unsigned IMG_W         = 640,
  parameter int unsigned IMG_H         = 480,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned AFULL_LVL     = 12,
  localparam int unsigned PIX_W        = 8 * BYTES_PER_PIX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             byte_vld_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_rdy_o,
  output logic             pix_vld_o,
  input  logic             pix_rdy_i,
  output logic [PIX_W-1:0] pix_data_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic             hold_o,
  output logic             frame_done_o,
  output logic             overflow_o
);
  localparam int unsigned COL_W   = $clog2(IMG_W);
  localparam int unsigned ROW_W   = $clog2(IMG_H);
  localparam int unsigned CNT_W   = $clog2(BYTES_PER_PIX + 1);
  localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_PIX - 1);

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [PIX_W-1:0] pix;
  } entry_t;

  asm_state_e         state_q;
  logic [CNT_W-1:0]   byte_cnt_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [PIX_W-9:0]   acc_q;
  logic [PIX_W-1:0]   pix_cat;
  entry_t             entry_q, head;
  logic               push_q, frame_done_q, hold_q, overflow_q;
  logic               fifo_full, fifo_empty, pop, push_ok, hold_d;
  logic [FIFO_CW-1:0] fifo_count, count_nxt;

  // Earlier bytes sit in acc_q; the current byte lands on top, so byte 0 ends up in bits [7:0].
  assign pix_cat = {byte_data_i, acc_q};
  assign pop     = pix_vld_o && pix_rdy_i;
  assign push_ok = push_q && (!fifo_full || pop);

  always_comb begin
    count_nxt = fifo_count;
    if (push_ok && !pop)      count_nxt = fifo_count + 1'b1;
    else if (pop && !push_ok) count_nxt = fifo_count - 1'b1;
    hold_d = (count_nxt >= FIFO_CW'(AFULL_LVL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      col_q        <= '0;
      row_q        <= '0;
      acc_q        <= '0;
      entry_q      <= '0;
      push_q       <= 1'b0;
      frame_done_q <= 1'b0;
      hold_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      push_q       <= 1'b0;
      frame_done_q <= 1'b0;
      hold_q       <= hold_d;
      if (push_q && fifo_full && !pop) overflow_q <= 1'b1;
      case (state_q)
        IDLE: if (byte_vld_i && byte_data_i == SYNC_BYTE) state_q <= RECV;
        RECV: if (byte_vld_i) begin
          acc_q <= pix_cat[PIX_W-1:8];
          if (byte_cnt_q == CNT_LAST) begin
            byte_cnt_q  <= '0;
            push_q      <= 1'b1;
            entry_q.sof <= (col_q == '0) && (row_q == '0);
            entry_q.eol <= (col_q == COL_LAST);
            entry_q.pix <= pix_cat;
            if (col_q == COL_LAST) begin
              col_q <= '0;
              if (row_q == ROW_LAST) begin
                row_q        <= '0;
                state_q      <= DONE;
                frame_done_q <= 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end else begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          byte_cnt_q <= '0;
          col_q      <= '0;
          row_q      <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_pix_assembler_sync_fifo #(
    .WIDTH(PIX_W + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_q),
    .din_i  (entry_q),
    .pop_i  (pop),
    .head_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign byte_rdy_o   = 1'b1;
  assign pix_vld_o    = !fifo_empty;
  assign pix_data_o   = head.pix;
  assign sof_o        = head.sof;
  assign eol_o        = head.eol;
  assign hold_o       = hold_q;
  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_uart_pix_assembler.sv
// Bench for uart_pix_assembler on a 2x2 frame with a 4-deep FIFO: directed steps then random frames.
module tb_uart_pix_assembler;
  localparam int unsigned W = 2, H = 2, DEPTH = 4, AFULL = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        byte_vld_i = 1'b0;
  logic [7:0]  byte_data_i = '0;
  logic        byte_rdy_o;
  logic        pix_vld_o, pix_rdy_i = 1'b1;
  logic [23:0] pix_data_o;
  logic        sof_o, eol_o, hold_o, frame_done_o, overflow_o;

  int          vecs = 0, errs = 0;
  int          rdy_mode = 1;          // 0: stall, 1: always ready, 2: random ready
  bit          last_low = 1'b0;
  logic [25:0] exp_q[$];
  int          fd_cnt = 0, fd_exp = 0;
  bit          m_in = 1'b0;
  int          m_bi = 0, m_k = 0;
  logic [23:0] m_acc = '0;
  bit          stall_pend = 1'b0;
  logic [25:0] stall_val = '0;

  always #5 clk = ~clk;

  uart_pix_assembler #(
    .BYTES_PER_PIX(3),
    .IMG_W        (W),
    .IMG_H        (H),
    .FIFO_DEPTH   (DEPTH),
    .AFULL_LVL    (AFULL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_vld_i  (byte_vld_i),
    .byte_data_i (byte_data_i),
    .byte_rdy_o  (byte_rdy_o),
    .pix_vld_o   (pix_vld_o),
    .pix_rdy_i   (pix_rdy_i),
    .pix_data_o  (pix_data_o),
    .sof_o       (sof_o),
    .eol_o       (eol_o),
    .hold_o      (hold_o),
    .frame_done_o(frame_done_o),
    .overflow_o  (overflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ready driver; random mode never stalls two cycles in a row so the FIFO cannot fill.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       pix_rdy_i = 1'b0;
      1:       pix_rdy_i = 1'b1;
      default: pix_rdy_i = last_low ? 1'b1 : ($urandom_range(0, 3) != 0);
    endcase
    last_low = !pix_rdy_i;
  end

  // Output monitor: every transfer is matched against the reference queue; stalled heads must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (frame_done_o) fd_cnt++;
      if (stall_pend) chk("stall_stable", {pix_vld_o, sof_o, eol_o, pix_data_o}, {1'b1, stall_val});
      if (pix_vld_o && pix_rdy_i) begin
        chk("pix_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("pix_data", {sof_o, eol_o, pix_data_o}, exp_q.pop_front());
        stall_pend = 1'b0;
      end else if (pix_vld_o) begin
        stall_pend = 1'b1;
        stall_val  = {sof_o, eol_o, pix_data_o};
      end else begin
        stall_pend = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reference frame parser: sync byte opens a frame of W*H pixels, 3 bytes each, little-endian.
  task automatic send(input logic [7:0] b, input bit keep = 1'b1);
    bit          has = 1'b0;
    logic [25:0] e = '0;
    if (!m_in) begin
      m_in = (b == 8'hA5);
    end else begin
      m_acc[8*m_bi +: 8] = b;
      m_bi++;
      if (m_bi == 3) begin
        has  = 1'b1;
        e    = {m_k == 0, (m_k % W) == W - 1, m_acc};
        m_bi = 0;
        m_k++;
        if (m_k == W * H) begin m_in = 1'b0; m_k = 0; fd_exp++; end
      end
    end
    if (has && keep) exp_q.push_back(e);
    byte_vld_i  = 1'b1;
    byte_data_i = b;
    @(posedge clk); #1;
    byte_vld_i  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
    idle(1);
    chk({tag, "_empty"}, exp_q.size(), 0);
    chk({tag, "_vld"}, pix_vld_o, 0);
    chk({tag, "_frames"}, fd_cnt, fd_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] t2 [9];
    logic [7:0] rb;
    int         nj;
    t2 = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

    idle(3);
    chk("reset_outs", {pix_vld_o, sof_o, eol_o, hold_o, frame_done_o, overflow_o}, 0);
    chk("reset_data", pix_data_o, 0);
    chk("byte_rdy", byte_rdy_o, 1);
    rst_n = 1'b1;
    idle(1);

    // First pixel and its two-cycle latency
    send(8'hA5); send(8'h11); send(8'h22); send(8'h33);
    chk("lat_cyc1_vld", pix_vld_o, 0);
    idle(1);
    chk("lat_cyc2_vld", pix_vld_o, 1);
    chk("first_pix", {sof_o, eol_o, pix_data_o}, {2'b10, 24'h332211});

    // Rest of the frame
    for (int i = 0; i < 9; i++) send(t2[i]);
    idle(3);
    drain("frame1");

    // Junk before sync is ignored
    send(8'h00); send(8'hFF); send(8'hA5);
    for (int i = 0; i < 12; i++) send(8'($urandom));
    drain("junk_frame");

    // Stalled output: hold threshold, overflow drop, ordered drain
    rdy_mode = 0;
    idle(2);
    send(8'hA5);
    for (int i = 0; i < 9; i++) send(8'($urandom));
    chk("hold_two", hold_o, 0);
    idle(1);
    chk("hold_three", hold_o, 1);
    for (int i = 0; i < 3; i++) send(8'($urandom));
    idle(2);
    send(8'hA5);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    idle(3);
    chk("ovf_set", overflow_o, 1);
    chk("full_vld", pix_vld_o, 1);
    chk("full_head", {sof_o, eol_o, pix_data_o}, exp_q[0]);
    idle(4);
    rdy_mode = 1;
    drain("ovf_drain");
    chk("hold_clear", hold_o, 0);
    chk("ovf_sticky", overflow_o, 1);

    // Reset mid-pixel
    send(8'h12); send(8'h34);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {pix_vld_o, sof_o, eol_o, hold_o, frame_done_o, overflow_o}, 0);
    chk("midrst_data", pix_data_o, 0);
    idle(2);
    m_in = 1'b0; m_bi = 0; m_k = 0; exp_q.delete();
    rst_n = 1'b1;
    idle(1);
    send(8'hA5);
    for (int i = 0; i < 12; i++) send(8'($urandom));
    drain("post_rst");

    // Push and pop together while full
    rdy_mode = 0;
    idle(2);
    send(8'hA5);
    for (int i = 0; i < 12; i++) send(8'($urandom));
    idle(2);
    send(8'hA5);
    for (int i = 0; i < 3; i++) send(8'($urandom));
    chk("full_hold", hold_o, 1);
    rdy_mode = 1;
    idle(3);
    chk("simul_no_ovf", overflow_o, 0);
    for (int i = 0; i < 9; i++) send(8'($urandom));
    drain("simul");

    // Random frames with random gaps, junk and ready
    rdy_mode = 2;
    for (int f = 0; f < 20; f++) begin
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        rb = 8'($urandom);
        if (rb == 8'hA5) rb = 8'h5A;
        send(rb);
        idle($urandom_range(0, 1));
      end
      send(8'hA5);
      for (int j = 0; j < 12; j++) begin
        send(8'($urandom));
        idle($urandom_range(0, 2));
      end
      idle(2);
    end
    rdy_mode = 1;
    idle(2);
    drain("random");
    chk("random_no_ovf", overflow_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
